// File: rtl/xpsr_ctx_stack_if.sv
// Register-file-side signal bundle for xpsr_ctx_stack: write strobes, exception events and xPSR views.
// XPSR_GE_EN adds the en_ge/ge pair.
interface xpsr_ctx_stack_if #(
    parameter int IPSR_W = 9,
    parameter int CNT_W  = 3
);
    logic [31:0]       set_data;
    logic [4:0]        en_apsr;
    logic              en_ipsr;
    logic              en_epsr;
    logic              inst_valid;
    logic              exc_entry;
    logic [IPSR_W-1:0] exc_num;
    logic              exc_return;
    logic              stk_err_clr;
`ifdef XPSR_GE_EN
    logic              en_ge;
    logic [3:0]        ge;
`endif

    logic [4:0]        apsr;
    logic [IPSR_W-1:0] ipsr;
    logic [9:0]        epsr;
    logic [31:0]       xpsr;
    logic              in_it_blk;
    logic [3:0]        it_cond;
    logic [CNT_W-1:0]  stk_level;
    logic              stk_full;
    logic              stk_empty;
    logic              stk_err;

    modport master (
`ifdef XPSR_GE_EN
        output en_ge,
        input  ge,
`endif
        output set_data, en_apsr, en_ipsr, en_epsr, inst_valid,
        output exc_entry, exc_num, exc_return, stk_err_clr,
        input  apsr, ipsr, epsr, xpsr, in_it_blk, it_cond,
        input  stk_level, stk_full, stk_empty, stk_err
    );

    modport slave (
`ifdef XPSR_GE_EN
        input  en_ge,
        output ge,
`endif
        input  set_data, en_apsr, en_ipsr, en_epsr, inst_valid,
        input  exc_entry, exc_num, exc_return, stk_err_clr,
        output apsr, ipsr, epsr, xpsr, in_it_blk, it_cond,
        output stk_level, stk_full, stk_empty, stk_err
    );
endinterface

// File: rtl/xpsr_ctx_stack.sv
// xPSR register (APSR/IPSR/EPSR, IT advance) with a hardware context stack for nested exceptions.
// Optional GE flags are built when XPSR_GE_EN is defined.
module xpsr_ctx_stack #(
    parameter int IPSR_W    = 9,
    parameter int STK_DEPTH = 4,
    parameter int CNT_W     = 3
) (
    input logic             clk,
    input logic             rst,
    xpsr_ctx_stack_if.slave bus
);
    localparam logic [9:0] EPSR_RST  = 10'b0010000000;
    localparam logic [9:0] EPSR_KEEP = 10'b0010000001;
    localparam int         AW        = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;

`ifdef XPSR_GE_EN
    localparam int FRAME_W = 5 + 4 + IPSR_W + 10;
    logic [3:0] ge_q;
`else
    localparam int FRAME_W = 5 + IPSR_W + 10;
`endif

    logic [4:0]        apsr_q;
    logic [IPSR_W-1:0] ipsr_q;
    logic [9:0]        epsr_q;
    logic [CNT_W-1:0]  level_q;
    logic              err_q;

    logic [FRAME_W-1:0] stack [STK_DEPTH];
    logic [FRAME_W-1:0] push_frame;
    logic [FRAME_W-1:0] pop_frame;
    logic [AW-1:0]      push_idx;
    logic [AW-1:0]      pop_idx;

    logic [7:0] it;
    logic [7:0] it_next;
    logic [9:0] epsr_adv;
    logic [8:0] ipsr_ext;
    logic       in_blk;
    logic       full;
    logic       empty;
    logic       exc_evt;
    logic       tail;
    logic       do_push;
    logic       do_pop;
    logic       err_set;
    logic       any_en;
    logic       it_adv;

    // IT bits are scattered across EPSR: IT[7:2]=epsr[6:1], IT[1:0]=epsr[9:8]
    assign it     = {epsr_q[6:1], epsr_q[9:8]};
    assign in_blk = |it[3:0];

    always_comb begin
        it_next = '0;
        if (it[2:0] != 3'b000) begin
            it_next = {it[7:5], it[3:0], 1'b0};
        end
    end
    assign epsr_adv = {it_next[1:0], epsr_q[7], it_next[7:2], epsr_q[0]};

    assign full    = (level_q == CNT_W'(STK_DEPTH));
    assign empty   = (level_q == '0);
    assign exc_evt = bus.exc_entry | bus.exc_return;
    assign tail    = bus.exc_entry & bus.exc_return;
    assign do_push = bus.exc_entry & ~bus.exc_return & ~full;
    assign do_pop  = bus.exc_return & ~bus.exc_entry & ~empty;
    assign err_set = (bus.exc_entry & ~bus.exc_return & full) |
                     (bus.exc_return & ~bus.exc_entry & empty);

`ifdef XPSR_GE_EN
    assign any_en     = (|bus.en_apsr) | bus.en_ipsr | bus.en_epsr | bus.en_ge;
    assign push_frame = {apsr_q, ge_q, ipsr_q, epsr_q};
`else
    assign any_en     = (|bus.en_apsr) | bus.en_ipsr | bus.en_epsr;
    assign push_frame = {apsr_q, ipsr_q, epsr_q};
`endif
    assign it_adv = ~exc_evt & ~any_en & bus.inst_valid & in_blk;

    assign push_idx  = AW'(level_q);
    assign pop_idx   = AW'(level_q - CNT_W'(1));
    assign pop_frame = stack[pop_idx];

    // Frame storage has no reset; only the level counter decides which frames are live.
    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            stack[push_idx] <= push_frame;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            apsr_q  <= '0;
            ipsr_q  <= '0;
            epsr_q  <= EPSR_RST;
            level_q <= '0;
            err_q   <= 1'b0;
`ifdef XPSR_GE_EN
            ge_q    <= '0;
`endif
        end else begin
            if (err_set) begin
                err_q <= 1'b1;
            end else if (bus.stk_err_clr) begin
                err_q <= 1'b0;
            end

            if (tail || do_push) begin
                ipsr_q <= bus.exc_num;
                epsr_q <= epsr_q & EPSR_KEEP;
                if (do_push) begin
                    level_q <= level_q + CNT_W'(1);
                end
            end else if (do_pop) begin
                apsr_q  <= pop_frame[FRAME_W-1 -: 5];
                ipsr_q  <= pop_frame[10 +: IPSR_W];
                epsr_q  <= pop_frame[9:0];
`ifdef XPSR_GE_EN
                ge_q    <= pop_frame[10+IPSR_W +: 4];
`endif
                level_q <= level_q - CNT_W'(1);
            end else if (!exc_evt) begin
                for (int unsigned i = 0; i < 5; i++) begin
                    if (bus.en_apsr[i]) begin
                        apsr_q[i] <= bus.set_data[27+i];
                    end
                end
                if (bus.en_ipsr) begin
                    ipsr_q <= bus.set_data[IPSR_W-1:0];
                end
                if (bus.en_epsr) begin
                    epsr_q <= {bus.set_data[26:24], bus.set_data[15:9]};
                end else if (it_adv) begin
                    epsr_q <= epsr_adv;
                end
`ifdef XPSR_GE_EN
                if (bus.en_ge) begin
                    ge_q <= bus.set_data[19:16];
                end
`endif
            end
        end
    end

    assign ipsr_ext = 9'(ipsr_q);

    assign bus.apsr      = apsr_q;
    assign bus.ipsr      = ipsr_q;
    assign bus.epsr      = epsr_q;
    assign bus.in_it_blk = in_blk;
    assign bus.it_cond   = in_blk ? it[7:4] : 4'b1110;
    assign bus.stk_level = level_q;
    assign bus.stk_full  = full;
    assign bus.stk_empty = empty;
    assign bus.stk_err   = err_q;

`ifdef XPSR_GE_EN
    logic unused_bits;
    assign unused_bits = ^bus.set_data[23:20];
    assign bus.ge      = ge_q;
    assign bus.xpsr    = {apsr_q, epsr_q[9:8], epsr_q[7], 4'b0000, ge_q,
                          epsr_q[6:1], epsr_q[0], ipsr_ext};
`else
    logic unused_bits;
    assign unused_bits = ^bus.set_data[23:16];
    assign bus.xpsr    = {apsr_q, epsr_q[9:8], epsr_q[7], 4'b0000, 4'b0000,
                          epsr_q[6:1], epsr_q[0], ipsr_ext};
`endif
endmodule

// File: tb/tb_xpsr_ctx_stack.sv
// Scoreboard bench for xpsr_ctx_stack: directed scenarios then random traffic against a queue-based model.
// Honors XPSR_GE_EN when defined.
`timescale 1ns/1ps
module tb_xpsr_ctx_stack;
    localparam int IPSR_W    = 9;
    localparam int STK_DEPTH = 4;
    localparam int CNT_W     = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    xpsr_ctx_stack_if #(.IPSR_W(IPSR_W), .CNT_W(CNT_W)) bus ();

    xpsr_ctx_stack #(.IPSR_W(IPSR_W), .STK_DEPTH(STK_DEPTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic        rst;
        logic [31:0] set_data;
        logic [4:0]  en_apsr;
        logic        en_ipsr;
        logic        en_epsr;
        logic        en_ge;
        logic        inst_valid;
        logic        exc_entry;
        logic [8:0]  exc_num;
        logic        exc_return;
        logic        stk_err_clr;
    } stim_t;

    typedef struct {
        logic [4:0] apsr;
        logic [3:0] ge;
        logic [8:0] ipsr;
        logic [7:0] it;
        logic       t;
        logic       a;
    } frame_t;

    typedef struct {
        logic [31:0] xpsr;
        logic [4:0]  apsr;
        logic [8:0]  ipsr;
        logic [9:0]  epsr;
        logic        in_blk;
        logic [3:0]  cond;
        logic [2:0]  level;
        logic        full;
        logic        empty;
        logic        err;
        logic [3:0]  ge;
    } exp_t;

    frame_t cur;
    frame_t m_stk[$];
    logic   m_err;
    exp_t   exp_q[$];

    int vectors     = 0;
    int miscompares = 0;
    int n_checks    = 0;

    task automatic model_step(input stim_t s);
        logic err_new;
        logic any_en;
        err_new = 1'b0;
        if (s.rst) begin
            cur.apsr = '0;
            cur.ge   = '0;
            cur.ipsr = '0;
            cur.it   = '0;
            cur.t    = 1'b1;
            cur.a    = 1'b0;
            m_stk.delete();
            m_err = 1'b0;
        end else begin
            if (s.exc_entry && s.exc_return) begin
                cur.ipsr = s.exc_num;
                cur.it   = '0;
            end else if (s.exc_entry) begin
                if (m_stk.size() >= STK_DEPTH) begin
                    err_new = 1'b1;
                end else begin
                    m_stk.push_back(cur);
                    cur.ipsr = s.exc_num;
                    cur.it   = '0;
                end
            end else if (s.exc_return) begin
                if (m_stk.size() == 0) err_new = 1'b1;
                else cur = m_stk.pop_back();
            end else begin
                any_en = (s.en_apsr != 0) || s.en_ipsr || s.en_epsr || s.en_ge;
                for (int i = 0; i < 5; i++) begin
                    if (s.en_apsr[i]) cur.apsr[i] = s.set_data[27+i];
                end
                if (s.en_ipsr) cur.ipsr = s.set_data[8:0];
                if (s.en_ge) cur.ge = s.set_data[19:16];
                if (s.en_epsr) begin
                    cur.t  = s.set_data[24];
                    cur.a  = s.set_data[9];
                    cur.it = {s.set_data[15:10], s.set_data[26:25]};
                end
                if (!any_en && s.inst_valid && cur.it[3:0] != 4'h0) begin
                    if (cur.it[2:0] == 3'b000) cur.it = '0;
                    else cur.it = {cur.it[7:5], cur.it[3:0], 1'b0};
                end
            end
            if (err_new) m_err = 1'b1;
            else if (s.stk_err_clr) m_err = 1'b0;
        end
    endtask

    function automatic exp_t predict();
        exp_t e;
        e.apsr   = cur.apsr;
        e.ipsr   = cur.ipsr;
        e.epsr   = {cur.it[1:0], cur.t, cur.it[7:2], cur.a};
        e.xpsr   = {cur.apsr, cur.it[1:0], cur.t, 4'b0000, cur.ge, cur.it[7:2], cur.a, cur.ipsr};
        e.in_blk = (cur.it[3:0] != 4'h0);
        e.cond   = e.in_blk ? cur.it[7:4] : 4'hE;
        e.level  = 3'(m_stk.size());
        e.full   = (m_stk.size() == STK_DEPTH);
        e.empty  = (m_stk.size() == 0);
        e.err    = m_err;
        e.ge     = cur.ge;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (vector %0d, t=%0t)", nm, act, expv, vectors, $time);
        end
    endtask

    // Monitor: one expected snapshot per clock edge, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                chk("xpsr", bus.xpsr, e.xpsr);
                chk("apsr", 32'(bus.apsr), 32'(e.apsr));
                chk("ipsr", 32'(bus.ipsr), 32'(e.ipsr));
                chk("epsr", 32'(bus.epsr), 32'(e.epsr));
                chk("in_it_blk", 32'(bus.in_it_blk), 32'(e.in_blk));
                chk("it_cond", 32'(bus.it_cond), 32'(e.cond));
                chk("stk_level", 32'(bus.stk_level), 32'(e.level));
                chk("stk_full", 32'(bus.stk_full), 32'(e.full));
                chk("stk_empty", 32'(bus.stk_empty), 32'(e.empty));
                chk("stk_err", 32'(bus.stk_err), 32'(e.err));
`ifdef XPSR_GE_EN
                chk("ge", 32'(bus.ge), 32'(e.ge));
`endif
            end
        end
    end

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic logic [31:0] it_data(input logic [7:0] itv);
        logic [31:0] d;
        d        = '0;
        d[26:25] = itv[1:0];
        d[24]    = 1'b1;
        d[15:10] = itv[7:2];
        return d;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        int r;
        s          = idle();
        s.rst      = ($urandom_range(0, 199) == 0);
        s.set_data = $urandom();
        if ($urandom_range(0, 3) == 0) s.en_apsr = 5'($urandom());
        s.en_ipsr    = ($urandom_range(0, 9) == 0);
        s.en_epsr    = ($urandom_range(0, 5) == 0);
`ifdef XPSR_GE_EN
        s.en_ge      = ($urandom_range(0, 7) == 0);
`endif
        s.inst_valid = ($urandom_range(0, 2) != 0);
        r            = $urandom_range(0, 19);
        s.exc_entry  = (r < 3) || (r == 19);
        s.exc_return = (r >= 3 && r < 6) || (r == 19);
        s.exc_num    = 9'($urandom());
        s.stk_err_clr = ($urandom_range(0, 15) == 0);
        return s;
    endfunction

    task automatic drive(input stim_t s);
        @(negedge clk);
        rst             = s.rst;
        bus.set_data    = s.set_data;
        bus.en_apsr     = s.en_apsr;
        bus.en_ipsr     = s.en_ipsr;
        bus.en_epsr     = s.en_epsr;
`ifdef XPSR_GE_EN
        bus.en_ge       = s.en_ge;
`endif
        bus.inst_valid  = s.inst_valid;
        bus.exc_entry   = s.exc_entry;
        bus.exc_num     = s.exc_num;
        bus.exc_return  = s.exc_return;
        bus.stk_err_clr = s.stk_err_clr;
        model_step(s);
        exp_q.push_back(predict());
    endtask

    initial begin
        stim_t s;
        bus.set_data    = '0;
        bus.en_apsr     = '0;
        bus.en_ipsr     = 1'b0;
        bus.en_epsr     = 1'b0;
`ifdef XPSR_GE_EN
        bus.en_ge       = 1'b0;
`endif
        bus.inst_valid  = 1'b0;
        bus.exc_entry   = 1'b0;
        bus.exc_num     = '0;
        bus.exc_return  = 1'b0;
        bus.stk_err_clr = 1'b0;

        // reset state
        s = idle(); s.rst = 1'b1;
        drive(s); drive(s);
        drive(idle());

        // four-instruction IT block, then a retire outside any block
        s = idle(); s.en_epsr = 1'b1; s.set_data = it_data(8'h01); drive(s);
        repeat (5) begin s = idle(); s.inst_valid = 1'b1; drive(s); end
        s = idle(); s.en_epsr = 1'b1; s.set_data = it_data(8'hA6); drive(s);
        repeat (4) begin s = idle(); s.inst_valid = 1'b1; drive(s); end

        // entry/return round trip with flags and IT active
        s = idle(); s.en_apsr = 5'h1F; s.en_ipsr = 1'b1; s.en_epsr = 1'b1;
        s.set_data = it_data(8'h34) | 32'hA000_0000; drive(s);
        s = idle(); s.exc_entry = 1'b1; s.exc_num = 9'd11; drive(s);
        drive(idle());
        s = idle(); s.exc_return = 1'b1; drive(s);
        drive(idle());

        // overflow, unwind, underflow, sticky clear
        for (int i = 3; i <= 7; i++) begin
            s = idle(); s.exc_entry = 1'b1; s.exc_num = 9'(i); drive(s);
        end
        repeat (5) begin s = idle(); s.exc_return = 1'b1; drive(s); end
        s = idle(); s.stk_err_clr = 1'b1; drive(s);
        s = idle(); s.exc_return = 1'b1; s.stk_err_clr = 1'b1; drive(s);
        s = idle(); s.stk_err_clr = 1'b1; drive(s);

        // tail-chain at level 2
        s = idle(); s.en_epsr = 1'b1; s.set_data = it_data(8'h2C); drive(s);
        s = idle(); s.exc_entry = 1'b1; s.exc_num = 9'd1; drive(s);
        s = idle(); s.en_epsr = 1'b1; s.set_data = it_data(8'h52); drive(s);
        s = idle(); s.exc_entry = 1'b1; s.exc_num = 9'd2; drive(s);
        s = idle(); s.en_epsr = 1'b1; s.set_data = it_data(8'h13); drive(s);
        s = idle(); s.exc_entry = 1'b1; s.exc_return = 1'b1; s.exc_num = 9'd9; drive(s);
        repeat (2) begin s = idle(); s.exc_return = 1'b1; drive(s); end

        // a single flag write beats IT advance
        s = idle(); s.en_epsr = 1'b1; s.set_data = it_data(8'h05); drive(s);
        s = idle(); s.en_apsr = 5'b01000; s.inst_valid = 1'b1; s.set_data = '1; drive(s);
        s = idle(); s.en_ipsr = 1'b1; s.inst_valid = 1'b1; s.set_data = 32'h0000_0033; drive(s);
`ifdef XPSR_GE_EN
        s = idle(); s.en_ge = 1'b1; s.set_data = 32'h000A_0000; drive(s);
        s = idle(); s.exc_entry = 1'b1; s.exc_num = 9'd15; drive(s);
        s = idle(); s.en_ge = 1'b1; s.set_data = 32'h0005_0000; drive(s);
        s = idle(); s.exc_return = 1'b1; drive(s);
`endif

        // reset mid-nest discards frames
        repeat (3) begin s = idle(); s.exc_entry = 1'b1; s.exc_num = 9'd20; drive(s); end
        s = idle(); s.rst = 1'b1; drive(s);
        s = idle(); s.exc_return = 1'b1; drive(s);

        repeat (3000) drive(rand_stim());
        drive(idle());

        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d snapshots pending, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
